seq_event_logger: RTL and testbench

Downstream consumer of the sequence detector's one-bit match output. Each cycle in which the detector's `signal` is high is one event. The block stamps each event with a free-running cycle timestamp and buffers the stamps in a small FIFO. A downstream reader drains the stamps over a valid/ready handshake. The block also keeps saturating counts of accepted and dropped events.

---
 rtl/seq_event_logger.sv | 108 ++++++++++
 tb/tb_seq_event_logger.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_event_logger.sv
// seq_event_logger
//
// Timestamps every cycle in which the sequence detector's match strobe is
// high and buffers the stamps in a small FIFO for a downstream reader.
// Saturating counters track accepted events and events dropped on a full FIFO.
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous, active-high reset
//   signal     : event strobe; each cycle sampled high is one event
//   evt_valid  : FIFO head holds a stamp
//   evt_ready  : reader accepts the head entry
//   evt_ts     : head stamp, 0 when the FIFO is empty
//   evt_cnt    : saturating count of events accepted into the FIFO
//   ovf_cnt    : saturating count of events dropped because the FIFO was full
//   fifo_level : number of occupied entries, 0..DEPTH
//
// Handshake: a stamp is transferred at a rising edge where evt_valid and
// evt_ready are both high. evt_valid comes straight from the registered level
// and never depends combinationally on evt_ready or signal; evt_ready while
// the FIFO is empty has no effect.

module seq_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       signal,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_ts,
  output logic [CNT_W-1:0]           evt_cnt,
  output logic [CNT_W-1:0]           ovf_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;

  logic full;
  logic pop;
  logic push;
  logic drop;

  assign full      = (level == FULL_LVL);
  assign evt_valid = (level != '0);
  assign pop       = evt_valid & evt_ready;
  // A pop in the same edge frees the slot, so a full FIFO still accepts.
  assign push      = signal & (~full | pop);
  assign drop      = signal & full & ~pop;

  // Head is read straight from storage; zero it when nothing is buffered so
  // stale entries never leak out.
  assign evt_ts     = evt_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

  // Storage carries no reset: pointers and level define what is meaningful.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts      <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      evt_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      ts <= ts + TS_W'(1);

      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (push && (evt_cnt != CNT_MAX)) begin
        evt_cnt <= evt_cnt + CNT_W'(1);
      end
      if (drop && (ovf_cnt != CNT_MAX)) begin
        ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_event_logger.sv
// Testbench for seq_event_logger.
// Small TS_W/CNT_W values so timestamp wrap and counter saturation are
// reached quickly. A queue-based reference model updates on each rising edge;
// accepted stamps go into exp_q, and a monitor on the falling edge pops and
// compares whenever the DUT shows a handshake.

module tb_seq_event_logger;

  localparam int TS_W    = 5;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int TS_MOD  = 1 << TS_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic signal;
  logic evt_ready;
  logic evt_valid;
  logic [TS_W-1:0]  evt_ts;
  logic [CNT_W-1:0] evt_cnt;
  logic [CNT_W-1:0] ovf_cnt;
  logic [LW-1:0]    fifo_level;

  always #5 clk = ~clk;

  seq_event_logger #(
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .signal     (signal),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ts     (evt_ts),
    .evt_cnt    (evt_cnt),
    .ovf_cnt    (ovf_cnt),
    .fifo_level (fifo_level)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The FIFO is a plain queue: the reader's take happens first, then the new
  // event goes in if there is room.
  logic [TS_W-1:0] exp_q[$];
  int mdl_q[$];
  int mdl_ts  = 0;
  int mdl_evt = 0;
  int mdl_ovf = 0;
  bit checking = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_q.delete();
      exp_q.delete();
      mdl_ts   = 0;
      mdl_evt  = 0;
      mdl_ovf  = 0;
      checking = 1'b1;
    end else if (checking) begin
      if (evt_ready && mdl_q.size() > 0) begin
        void'(mdl_q.pop_front());
      end
      if (signal) begin
        if (mdl_q.size() < DEPTH) begin
          mdl_q.push_back(mdl_ts);
          exp_q.push_back(TS_W'(mdl_ts));
          if (mdl_evt < CNT_MAX) mdl_evt++;
        end else if (mdl_ovf < CNT_MAX) begin
          mdl_ovf++;
        end
      end
      mdl_ts = (mdl_ts + 1) % TS_MOD;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [TS_W-1:0] exp_head;

  always @(negedge clk) begin
    if (checking) begin
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_order: got stamp %0d, expected queue empty (t=%0t)", evt_ts, $time);
        end else begin
          exp_head = exp_q.pop_front();
          check("pop_order", 32'(evt_ts), 32'(exp_head));
        end
      end
      check("evt_valid",  32'(evt_valid),  32'(mdl_q.size() != 0));
      check("fifo_level", 32'(fifo_level), 32'(mdl_q.size()));
      check("evt_ts",     32'(evt_ts),     (mdl_q.size() != 0) ? 32'(mdl_q[0]) : 32'd0);
      check("evt_cnt",    32'(evt_cnt),    32'(mdl_evt));
      check("ovf_cnt",    32'(ovf_cnt),    32'(mdl_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic sig, input logic rdy, input int n = 1);
    for (int i = 0; i < n; i++) begin
      signal    = sig;
      evt_ready = rdy;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int drain_exp[4] = '{12, 14, 16, 20};
  int psig;
  int prdy;

  initial begin
    rst       = 1'b1;
    signal    = 1'b0;
    evt_ready = 1'b0;
    cycle(1'b0, 1'b0, 2);
    rst = 1'b0;

    // Reset state.
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_ts",    32'(evt_ts),    32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_evt",   32'(evt_cnt),   32'd0);
    check("rst_ovf",   32'(ovf_cnt),   32'd0);

    // Single event at ts=5.
    cycle(1'b0, 1'b0, 5);
    cycle(1'b1, 1'b0);
    check("single_valid", 32'(evt_valid),  32'd1);
    check("single_ts",    32'(evt_ts),     32'd5);
    check("single_level", 32'(fifo_level), 32'd1);
    check("single_evt",   32'(evt_cnt),    32'd1);
    check("single_ovf",   32'(ovf_cnt),    32'd0);

    // Overflow: pulses at ts 10,12,14,16,18 with no reader.
    do_reset();
    for (int t = 0; t <= 18; t++) begin
      cycle((t >= 10) && (t % 2 == 0), 1'b0);
    end
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_evt",   32'(evt_cnt),    32'd4);
    check("ovf_ovf",   32'(ovf_cnt),    32'd1);
    check("ovf_head",  32'(evt_ts),     32'd10);

    // Simultaneous push and pop while full at ts=20.
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    check("pp_head",  32'(evt_ts),     32'd12);
    check("pp_level", 32'(fifo_level), 32'd4);
    check("pp_ovf",   32'(ovf_cnt),    32'd1);
    check("pp_evt",   32'(evt_cnt),    32'd5);
    for (int i = 0; i < 4; i++) begin
      check("drain_ts", 32'(evt_ts), 32'(drain_exp[i]));
      cycle(1'b0, 1'b1);
    end
    check("drain_valid", 32'(evt_valid), 32'd0);
    check("drain_ts0",   32'(evt_ts),    32'd0);

    // Timestamp wrap: the 34th edge after release sees ts = 33 mod 32 = 1.
    do_reset();
    cycle(1'b0, 1'b0, 33);
    cycle(1'b1, 1'b0);
    check("wrap_ts", 32'(evt_ts), 32'd1);
    cycle(1'b0, 1'b1, 2);

    // Counter saturation with an always-ready reader.
    do_reset();
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b1);
    end
    check("sat_evt",   32'(evt_cnt),    32'(CNT_MAX));
    check("sat_ovf",   32'(ovf_cnt),    32'd0);
    check("sat_level", 32'(fifo_level), 32'd0);

    // Reset mid-operation together with an event.
    do_reset();
    cycle(1'b1, 1'b0, 3);
    check("mid_level", 32'(fifo_level), 32'd3);
    rst = 1'b1;
    cycle(1'b1, 1'b0);
    rst = 1'b0;
    check("mid_valid", 32'(evt_valid),  32'd0);
    check("mid_ts",    32'(evt_ts),     32'd0);
    check("mid_lvl0",  32'(fifo_level), 32'd0);
    check("mid_evt",   32'(evt_cnt),    32'd0);
    check("mid_ovf",   32'(ovf_cnt),    32'd0);
    cycle(1'b0, 1'b0, 2);
    cycle(1'b1, 1'b0);
    check("mid_stamp", 32'(evt_ts),  32'd2);
    check("mid_evt1",  32'(evt_cnt), 32'd1);

    // Randomized traffic with varying event and reader rates.
    for (int blk = 0; blk < 12; blk++) begin
      psig = $urandom_range(10, 95);
      prdy = $urandom_range(10, 95);
      for (int i = 0; i < 250; i++) begin
        rst = ($urandom_range(0, 399) == 0);
        cycle($urandom_range(0, 99) < psig, $urandom_range(0, 99) < prdy);
      end
    end
    rst = 1'b0;
    cycle(1'b0, 1'b1, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
